// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the multi-cycle radix-2 divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // rem < dvs always holds, so WIDTH+1 bits cannot overflow and diff[WIDTH] is the borrow
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_i};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage; drives the E-stage stall while busy.
// Define DIV_SIGNED_EN to honour signedE (magnitude conversion and sign correction).
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             annulE,
    output logic             div_stallE,
    output logic             div_validE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] a_mag, b_mag, hi_res, lo_res;
    logic             dz_q, valid_q;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, qneg_q, rneg_q;

    assign a_neg  = signedE & aE[WIDTH-1];
    assign b_neg  = signedE & bE[WIDTH-1];
    assign a_mag  = a_neg ? -aE : aE;
    assign b_mag  = b_neg ? -bE : bE;
    // Divide-by-zero leaves rem = |a|; negating by sign(a) restores a itself
    assign lo_res = dz_q ? '1 : (qneg_q ? -quo_d : quo_d);
    assign hi_res = rneg_q ? -rem_d : rem_d;
`else
    logic unused_signed;

    assign unused_signed = signedE;
    assign a_mag  = aE;
    assign b_mag  = bE;
    assign lo_res = dz_q ? '1 : quo_d;
    assign hi_res = rem_d;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (annulE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (startE) begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            dz_q    <= (bE == '0);
                            cnt_q   <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
`endif
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Result is registered on entry to DONE so it is visible with the pulse
                        if (cnt_q == '0) begin
                            hi_q    <= hi_res;
                            lo_q    <= lo_res;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign div_stallE = startE & ~annulE & ~rst & (state_q != DONE);
    assign div_validE = valid_q & ~annulE;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected HI/LO queued at issue, compared on each valid pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, startE, signedE, annulE;
    logic [31:0] aE, bE;
    logic        div_stallE, div_validE;
    logic [31:0] hi_o, lo_o;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

`ifdef DIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .startE     (startE),
        .signedE    (signedE),
        .aE         (aE),
        .bE         (bE),
        .annulE     (annulE),
        .div_stallE (div_stallE),
        .div_validE (div_validE),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        sb.push_back(e);
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] hi, output logic [31:0] lo);
        if (b == 32'd0) begin
            lo = '1;
            hi = a;
        end else if (SGN_EN && s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Scoreboard side: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (div_validE) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_hi"}, hi_o, e.hi);
                check({e.tag, "_lo"}, lo_o, e.lo);
            end
        end
    end

    // Caller sits just after a negedge; returns at the frame holding the valid pulse
    task automatic wait_valid(input bit scramble, output int cyc, output int stalls);
        bit done;
        cyc    = 0;
        stalls = 0;
        done   = 1'b0;
        while (!done) begin
            if (div_validE) begin
                check("stall_at_valid", {31'd0, div_stallE}, 32'd0);
                done = 1'b1;
            end else if (cyc >= 60) begin
                check("valid_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end else begin
                if (div_stallE) stalls++;
                @(negedge clk);
                cyc++;
                if (scramble) begin
                    aE = $urandom;
                    bE = $urandom;
                end
                #1;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit scramble);
        int cyc, stalls;
        @(negedge clk);
        startE  = 1'b1;
        signedE = s;
        aE      = a;
        bE      = b;
        #1;
        wait_valid(scramble, cyc, stalls);
        check({tag, "_latency"}, cyc, 32'd33);
        check({tag, "_stalls"}, stalls, 32'd33);
        @(negedge clk);
        startE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, stalls;
        logic [31:0] ra, rb, eh, el;
        logic        rs;

        rst = 1'b1; startE = 1'b1; annulE = 1'b0; signedE = 1'b0; aE = 32'd100; bE = 32'd7;
        repeat (3) begin
            @(negedge clk); #1;
            check("stall_in_rst", {31'd0, div_stallE}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; startE = 1'b0;
        #1;
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_valid", {31'd0, div_validE}, 32'd0);

        push_exp("divu_100_7", 32'd2, 32'd14);
        do_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b1);

        if (SGN_EN) push_exp("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        else        push_exp("div_m7_2", 32'd1, 32'h7FFF_FFFC);
        do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);

        if (SGN_EN) push_exp("div_ovf", 32'd0, 32'h8000_0000);
        else        push_exp("div_ovf", 32'h8000_0000, 32'd0);
        do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

        push_exp("divu_5_0", 32'd5, 32'hFFFF_FFFF);
        do_op("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0);

        // Squash in BUSY cycle 10: nothing completes and HI/LO keep 5 / all-ones
        @(negedge clk);
        startE = 1'b1; signedE = 1'b0; aE = 32'd1000; bE = 32'd3;
        repeat (10) @(negedge clk);
        annulE = 1'b1;
        #1;
        check("annul_stall", {31'd0, div_stallE}, 32'd0);
        @(negedge clk);
        annulE = 1'b0; startE = 1'b0;
        #1;
        check("annul_hi_now", hi_o, 32'd5);
        check("annul_lo_now", lo_o, 32'hFFFF_FFFF);
        repeat (40) @(negedge clk);
        #1;
        check("annul_hi_later", hi_o, 32'd5);
        check("annul_lo_later", lo_o, 32'hFFFF_FFFF);

        push_exp("divu_9_3", 32'd0, 32'd3);
        do_op("divu_9_3", 32'd9, 32'd3, 1'b0, 1'b0);

        // Start and annul together in IDLE: no operation may begin
        @(negedge clk);
        startE = 1'b1; annulE = 1'b1; aE = 32'd50; bE = 32'd5;
        repeat (3) begin
            #1;
            check("annul_idle_stall", {31'd0, div_stallE}, 32'd0);
            @(negedge clk);
        end
        startE = 1'b0; annulE = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("annul_idle_lo", lo_o, 32'd3);

        // Reset in BUSY cycle 20
        @(negedge clk);
        startE = 1'b1; aE = 32'd77; bE = 32'd4;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy_stall", {31'd0, div_stallE}, 32'd0);
        @(negedge clk);
        rst = 1'b0; startE = 1'b0;
        #1;
        check("rst_busy_hi", hi_o, 32'd0);
        check("rst_busy_lo", lo_o, 32'd0);
        check("rst_busy_valid", {31'd0, div_validE}, 32'd0);
        repeat (40) @(negedge clk);

        // Back-to-back with start held through the DONE cycle
        @(negedge clk);
        startE = 1'b1; signedE = 1'b0; aE = 32'd10; bE = 32'd3;
        push_exp("b2b_first", 32'd1, 32'd3);
        #1;
        wait_valid(1'b0, cyc, stalls);
        check("b2b_first_latency", cyc, 32'd33);
        @(negedge clk);
        aE = 32'd20; bE = 32'd6;
        push_exp("b2b_second", 32'd2, 32'd3);
        #1;
        wait_valid(1'b0, cyc, stalls);
        check("b2b_gap", cyc + 1, 32'd34);
        @(negedge clk);
        startE = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, eh, el);
            push_exp($sformatf("rand%0d", i), eh, el);
            do_op($sformatf("rand%0d", i), ra, rb, rs, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
